// File: rtl/mem_resp_router_pkg.sv
// Shared types and constants for the memory response router.
package mem_resp_router_pkg;

  localparam int WORD_W = 16;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_FETCH = 1'b0;
  localparam req_id_t REQ_ID_DATA  = 1'b1;

endpackage

// File: rtl/resp_id_fifo.sv
// Synchronous FIFO of 1-bit requester IDs, recorded in issue order.
// Callers must not push when full nor pop when empty.
module resp_id_fifo
  import mem_resp_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  req_id_t                  i_id,
  input  logic                     i_pop,
  output req_id_t                  o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  req_id_t       r_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is left unreset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_id;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_resp_router.sv
// Steers in-order memory responses to the fetch or data destination register.
// Define MEM_RESP_ROUTER_STATS_EN to add the if_count/dm_count load counters.
module mem_resp_router
  import mem_resp_router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_id,
  output logic                   issue_ready,
  input  logic                   resp_valid,
  input  logic [WIDTH-1:0]       resp_data,
  output logic                   resp_ready,
  output logic                   if_valid,
  output logic [WIDTH-1:0]       if_data,
  input  logic                   if_ready,
  output logic                   dm_valid,
  output logic [WIDTH-1:0]       dm_data,
  input  logic                   dm_ready,
  output logic [$clog2(DEPTH):0] outstanding,
`ifdef MEM_RESP_ROUTER_STATS_EN
  output logic [15:0]            if_count,
  output logic [15:0]            dm_count,
`endif
  output logic                   err_orphan
);

  req_id_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_accept;
  logic             w_head_free;
  logic             w_load_if;
  logic             w_load_dm;
  logic             r_if_valid;
  logic             r_dm_valid;
  logic [WIDTH-1:0] r_if_data;
  logic [WIDTH-1:0] r_dm_data;
  logic             r_err_orphan;

  resp_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_id    (issue_id),
    .i_pop   (w_accept),
    .o_head  (w_head),
    .o_count (outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A full FIFO refuses issues even when a pop happens in the same cycle.
  assign issue_ready = !w_full;
  assign w_push      = issue_valid && issue_ready;

  assign w_head_free = (w_head == REQ_ID_FETCH) ? (!r_if_valid || if_ready)
                                                : (!r_dm_valid || dm_ready);
  assign resp_ready  = !w_empty && w_head_free;
  assign w_accept    = resp_valid && resp_ready;
  assign w_load_if   = w_accept && (w_head == REQ_ID_FETCH);
  assign w_load_dm   = w_accept && (w_head == REQ_ID_DATA);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_valid   <= 1'b0;
      r_if_data    <= '0;
      r_dm_valid   <= 1'b0;
      r_dm_data    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      // A reload in the same cycle as a consume keeps the register valid.
      if (w_load_if) begin
        r_if_valid <= 1'b1;
        r_if_data  <= resp_data;
      end else if (if_ready) begin
        r_if_valid <= 1'b0;
      end
      if (w_load_dm) begin
        r_dm_valid <= 1'b1;
        r_dm_data  <= resp_data;
      end else if (dm_ready) begin
        r_dm_valid <= 1'b0;
      end
      if (resp_valid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  assign if_valid   = r_if_valid;
  assign if_data    = r_if_data;
  assign dm_valid   = r_dm_valid;
  assign dm_data    = r_dm_data;
  assign err_orphan = r_err_orphan;

`ifdef MEM_RESP_ROUTER_STATS_EN
  logic [15:0] r_if_count;
  logic [15:0] r_dm_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_count <= '0;
      r_dm_count <= '0;
    end else begin
      if (w_load_if) r_if_count <= r_if_count + 16'd1;
      if (w_load_dm) r_dm_count <= r_dm_count + 16'd1;
    end
  end

  assign if_count = r_if_count;
  assign dm_count = r_dm_count;
`endif

endmodule

// File: tb/tb_mem_resp_router.sv
// Randomized and directed bench for mem_resp_router against a queue-based model.
module tb_mem_resp_router;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_id = 1'b0;
  logic             issue_ready;
  logic             resp_valid = 1'b0;
  logic [WIDTH-1:0] resp_data = '0;
  logic             resp_ready;
  logic             if_valid;
  logic [WIDTH-1:0] if_data;
  logic             if_ready = 1'b1;
  logic             dm_valid;
  logic [WIDTH-1:0] dm_data;
  logic             dm_ready = 1'b1;
  logic [CW-1:0]    outstanding;
  logic             err_orphan;
`ifdef MEM_RESP_ROUTER_STATS_EN
  logic [15:0]      if_count;
  logic [15:0]      dm_count;
`endif

  mem_resp_router #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_id    (issue_id),
    .issue_ready (issue_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ready  (resp_ready),
    .if_valid    (if_valid),
    .if_data     (if_data),
    .if_ready    (if_ready),
    .dm_valid    (dm_valid),
    .dm_data     (dm_data),
    .dm_ready    (dm_ready),
    .outstanding (outstanding),
`ifdef MEM_RESP_ROUTER_STATS_EN
    .if_count    (if_count),
    .dm_count    (dm_count),
`endif
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending requester IDs plus two destination slots.
  bit          m_q[$];
  bit          m_live = 1'b0;
  bit          m_ifv, m_dmv, m_err;
  bit [15:0]   m_ifd, m_dmd;
  int unsigned m_ifc, m_dmc;

  function automatic bit m_dest_free(bit id);
    return (id == 1'b0) ? (!m_ifv || if_ready) : (!m_dmv || dm_ready);
  endfunction

  function automatic bit m_resp_ready();
    return (m_q.size() > 0) && m_dest_free(m_q[0]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_ifv = 0; m_dmv = 0; m_ifd = 0; m_dmd = 0; m_err = 0; m_ifc = 0; m_dmc = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      bit take, push, head;
      take = resp_valid && m_resp_ready();
      push = issue_valid && (m_q.size() < DEPTH);
      if (resp_valid && m_q.size() == 0) m_err = 1;
      head = take ? m_q[0] : 1'b0;
      if (take && head == 1'b0) begin m_ifv = 1; m_ifd = resp_data; m_ifc = (m_ifc + 1) % 65536; end
      else if (if_ready) m_ifv = 0;
      if (take && head == 1'b1) begin m_dmv = 1; m_dmd = resp_data; m_dmc = (m_dmc + 1) % 65536; end
      else if (dm_ready) m_dmv = 0;
      if (take) void'(m_q.pop_front());
      if (push) m_q.push_back(issue_id);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("issue_ready", 32'(issue_ready), 32'(m_q.size() < DEPTH));
      check("resp_ready",  32'(resp_ready),  32'(m_resp_ready()));
      check("outstanding", 32'(outstanding), 32'(m_q.size()));
      check("if_valid",    32'(if_valid),    32'(m_ifv));
      check("if_data",     32'(if_data),     32'(m_ifd));
      check("dm_valid",    32'(dm_valid),    32'(m_dmv));
      check("dm_data",     32'(dm_data),     32'(m_dmd));
      check("err_orphan",  32'(err_orphan),  32'(m_err));
`ifdef MEM_RESP_ROUTER_STATS_EN
      check("if_count",    32'(if_count),    32'(m_ifc));
      check("dm_count",    32'(dm_count),    32'(m_dmc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id);
    issue_valid = 1'b1;
    issue_id    = id;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    tick(); tick();
    check("rst outstanding", 32'(outstanding), 32'd0);
    check("rst issue_ready", 32'(issue_ready), 32'd1);
    check("rst resp_ready",  32'(resp_ready),  32'd0);
    check("rst if_data",     32'(if_data),     32'd0);
    rst_n = 1'b1;

    // In-order routing fetch, data, fetch with both readies high
    if_ready = 1'b1; dm_ready = 1'b1;
    issue(1'b0); issue(1'b1); issue(1'b0);
    check("t1 outstanding3", 32'(outstanding), 32'd3);
    resp_valid = 1'b1; resp_data = 16'h1111; tick();
    check("t1 if_valid", 32'(if_valid), 32'd1);
    check("t1 if_data",  32'(if_data),  32'h1111);
    resp_data = 16'h2222; tick();
    check("t1 dm_data",  32'(dm_data),  32'h2222);
    resp_data = 16'h3333; tick();
    check("t1 if_data2", 32'(if_data),  32'h3333);
    resp_valid = 1'b0;
    check("t1 outstanding0", 32'(outstanding), 32'd0);

    // Fill to DEPTH, extra issue refused, one pop reopens
    repeat (DEPTH) issue(1'b0);
    check("t2 issue_ready full", 32'(issue_ready), 32'd0);
    issue(1'b1);
    check("t2 outstanding full", 32'(outstanding), 32'(DEPTH));
    resp_valid = 1'b1; resp_data = 16'h0A0A; tick();
    check("t2 outstanding pop", 32'(outstanding), 32'(DEPTH - 1));
    check("t2 issue_ready",     32'(issue_ready), 32'd1);
    repeat (DEPTH - 1) tick();
    resp_valid = 1'b0;
    check("t2 drained", 32'(outstanding), 32'd0);

    // Head-of-line stall behind a blocked data destination
    if_ready = 1'b1; dm_ready = 1'b0;
    issue(1'b1); issue(1'b1); issue(1'b0);
    resp_valid = 1'b1; resp_data = 16'hAAAA; tick();
    check("t3 dm_data", 32'(dm_data), 32'hAAAA);
    resp_data = 16'hBBBB; tick(); tick();
    check("t3 stall resp_ready", 32'(resp_ready),  32'd0);
    check("t3 stall outst",      32'(outstanding), 32'd2);
    check("t3 stall dm_data",    32'(dm_data),     32'hAAAA);
    check("t3 if empty",         32'(if_valid),    32'd0);
    dm_ready = 1'b1; tick();
    check("t3 dm_data2", 32'(dm_data), 32'hBBBB);
    resp_data = 16'hCCCC; tick();
    check("t3 if_data",  32'(if_data), 32'hCCCC);
    resp_valid = 1'b0;

    // Orphan response
    resp_valid = 1'b1; tick();
    check("t4 orphan resp_ready", 32'(resp_ready), 32'd0);
    check("t4 err_orphan",        32'(err_orphan), 32'd1);
    resp_valid = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_id    = 1'($urandom_range(0, 1));
      resp_valid  = ($urandom_range(0, 3) != 0);
      resp_data   = 16'($urandom);
      if_ready    = ($urandom_range(0, 3) != 0);
      dm_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain, then confirm the error flag is still sticky
    issue_valid = 1'b0; if_ready = 1'b1; dm_ready = 1'b1; resp_valid = 1'b1;
    repeat (DEPTH + 2) tick();
    resp_valid = 1'b0; tick();
    check("t4 err sticky",   32'(err_orphan),  32'd1);
    check("drain outstanding", 32'(outstanding), 32'd0);

    // Reset mid-operation
    if_ready = 1'b0;
    repeat (DEPTH) issue(1'b0);
    resp_valid = 1'b1; resp_data = 16'h5A5A; tick();
    resp_valid = 1'b0;
    check("t5 pre outstanding", 32'(outstanding), 32'd3);
    check("t5 pre if_valid",    32'(if_valid),    32'd1);
    rst_n = 1'b0; tick();
    check("t5 outstanding", 32'(outstanding), 32'd0);
    check("t5 if_valid",    32'(if_valid),    32'd0);
    check("t5 issue_ready", 32'(issue_ready), 32'd1);
    check("t5 err_orphan",  32'(err_orphan),  32'd0);
    rst_n = 1'b1; if_ready = 1'b1;

`ifdef MEM_RESP_ROUTER_STATS_EN
    issue(1'b0); issue(1'b0); issue(1'b1); issue(1'b1);
    resp_valid = 1'b1; repeat (4) tick();
    resp_valid = 1'b0;
    issue(1'b0);
    resp_valid = 1'b1; tick();
    resp_valid = 1'b0;
    check("stats if_count", 32'(if_count), 32'd3);
    check("stats dm_count", 32'(dm_count), 32'd2);
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
